mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit that sits directly downstream of the register file read ports.
- Consumes rs1/rs2 operand values and the decoded funct3 and rd.
- Produces a single-cycle writeback (rd_out, result, wb_en) that drives the register file select/data_in/write_enable inputs.
- Radix-2: one operand bit per cycle; the core stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when busy=0
- flush  input  1  abort in-flight operation; no writeback
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  input  32  operand A (dividend / multiplicand)
- rs2_val  input  32  operand B (divisor / multiplier)
- rd_in  input  5  destination register index
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse with result valid
- result  output  32  writeback data, to register file data_in
- rd_out  output  5  writeback index, to register file select
- wb_en  output  1  done && rd_out!=0, to register file write_enable

Behaviour:
- Reset (async, any state) clears state to IDLE and sets busy=0, done=0, wb_en=0, result=0, rd_out=0.
- Reset also clears all internal accumulators and the counter.
- States are IDLE, CALC and DONE. busy=(state!=IDLE); done=(state==DONE).
- IDLE with start=1 at edge E0:
  - Latch funct3 and rd_in.
  - Signed ops: MULH both operands signed; MULHSU rs1 only; DIV/REM both. Latch the operand magnitudes and record the result sign:
    - product sign = sA^sB;
    - quotient sign = sA^sB;
    - remainder sign = sA (the dividend's sign).
  - Normal case: go to CALC with counter=0.
- Special cases go straight from IDLE to DONE (done high in the cycle after E0):
  - Divide by zero (rs2_val==0): DIV/DIVU result=32'hFFFFFFFF; REM/REMU result=rs1_val.
  - Signed overflow (DIV/REM with rs1=32'h80000000, rs2=32'hFFFFFFFF): DIV result=32'h80000000; REM result=0.
- CALC, multiply (shift-add):
  - Each cycle: if multiplier LSB is set, add the shifted multiplicand into the 64-bit accumulator; shift the multiplier right and the multiplicand left.
- CALC, divide (restoring):
  - Each cycle: shift {rem,quot} left 1; if rem>=divisor then rem-=divisor and set quot LSB.
- CALC lasts exactly 32 cycles (E1..E32). At E32 the unit:
  - applies two's-complement negation where the sign flag is set;
  - selects the low word (MUL), high word (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU);
  - registers the selected value into result and enters DONE.
- Latency: done is high in the cycle after E32 (33 cycles after the start edge).
- DONE lasts one cycle, then IDLE. result and rd_out hold their values until the next DONE.
- The earliest next accepted start is the edge after DONE, i.e. the cycle busy returns to 0.
- start while busy=1 is ignored (no queueing).
- flush:
  - In CALC or DONE it forces IDLE on the next edge with done=0 and wb_en=0; result is unchanged.
  - flush and start together in IDLE: flush wins and the start is dropped.
- rd_in=0: the operation runs normally and done pulses, but wb_en stays 0.
- Arithmetic widths: 64-bit accumulator for multiply; 33-bit compare/subtract for divide; 6-bit counter with no wrap (it saturates at the transition).

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: for multiply ops only, CALC exits to DONE at the end of any cycle in which the post-shift multiplier register is 0. The result is identical to the full 32-cycle computation.
  - Example: MULHU with rs2=1 has done high 2 cycles after the start edge.
  - rs2=0 is also handled by this rule.
- Undefined: every non-special operation takes exactly 32 CALC cycles.
- Divide timing is unaffected in both builds.

Test Plan:
- MUL rs1=7, rs2=6, rd=5 -> done/wb_en high 33 cycles after start; result=42; rd_out=5.
- MULH rs1=32'hFFFFFFFF (-1), rs2=32'hFFFFFFFF -> result=0.
- MULHSU rs1=32'hFFFFFFFF, rs2=32'hFFFFFFFF -> result=32'hFFFFFFFF.
- DIV rs1=-7, rs2=2 -> result=32'hFFFFFFFD (-3).
- REM with the same operands (-7, 2) -> result=32'hFFFFFFFF (-1).
- REMU rs1=100, rs2=7 -> result=2.
- Divide by zero: DIVU rs1=9, rs2=0 -> done 1 cycle after start, result=32'hFFFFFFFF.
- Overflow: REM 32'h80000000 / -1 -> result=0; DIV with the same operands -> result=32'h80000000, both in 1 cycle.
- Control and reset:
  - start re-asserted at cycle 10 of CALC -> ignored, exactly one done pulse.
  - flush at cycle 20 -> no done; busy=0 next cycle; result unchanged.
  - rd_in=0 -> done=1, wb_en=0.
  - rst pulsed mid-CALC -> all outputs 0 immediately, without waiting for a clock edge.
- MDU_EARLY_OUT_EN build:
  - MUL rs1=5, rs2=1 -> done 2 cycles after start, result=5.
  - MUL rs2=0 -> result=0.
  - DIV timing still 33 cycles.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Core-side operand/writeback bundle for the iterative RV32M multiply/divide unit.
interface mdu_iterative_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            wb_en;

  modport master (
    output start, flush, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, wb_en
  );

  modport slave (
    input  start, flush, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, wb_en
  );
endinterface

// File: rtl/mdu_iterative.sv
// Radix-2 iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro MDU_EARLY_OUT_EN: multiplies exit CALC once the multiplier is exhausted.
module mdu_iterative #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mdu_iterative_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;   // multiplicand, or divisor in the low word
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic [2*XLEN-1:0] mul_acc, div_acc, step_acc, prod;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub, quot, rem, sel, mplier_sh, mag_a, mag_b;
  logic              rem_ge, early, sa, sb, div_zero, div_ovf;

  // One datapath step; the final result is formed from the post-step value so E32 needs no extra cycle.
  always_comb begin
    mul_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_sh = mplier_q >> 1;
    rem_sh    = acc_q[2*XLEN-1:XLEN-1];
    rem_ge    = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
    rem_sub   = rem_sh[XLEN-1:0] - mcand_q[XLEN-1:0];
    div_acc   = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
    step_acc  = op_q[2] ? div_acc : mul_acc;
    prod      = qneg_q ? -step_acc : step_acc;
    quot      = qneg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem       = rneg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:                sel = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    sel = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          sel = quot;
      default:             sel = rem;
    endcase
`ifdef MDU_EARLY_OUT_EN
    early = !op_q[2] && (mplier_sh == '0);
`else
    early = 1'b0;
`endif
  end

  always_comb begin
    sa       = bus.rs1_val[XLEN-1] &&
               (bus.funct3 == 3'd1 || bus.funct3 == 3'd2 || bus.funct3 == 3'd4 || bus.funct3 == 3'd6);
    sb       = bus.rs2_val[XLEN-1] &&
               (bus.funct3 == 3'd1 || bus.funct3 == 3'd4 || bus.funct3 == 3'd6);
    mag_a    = sa ? -bus.rs1_val : bus.rs1_val;
    mag_b    = sb ? -bus.rs2_val : bus.rs2_val;
    div_zero = bus.funct3[2] && (bus.rs2_val == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.rs2_val == '1) &&
               (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}});
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d   = bus.funct3;
          rd_d   = bus.rd_in;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          cnt_d  = '0;
          if (bus.funct3[2]) begin
            acc_d    = {{XLEN{1'b0}}, mag_a};
            mcand_d  = {{XLEN{1'b0}}, mag_b};
            mplier_d = '0;
          end else begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag_a};
            mplier_d = mag_b;
          end
          if (div_zero) begin
            result_d = bus.funct3[1] ? bus.rs1_val : '1;
            rd_out_d = bus.rd_in;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            rd_out_d = bus.rd_in;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = step_acc;
          mcand_d  = op_q[2] ? mcand_q : (mcand_q << 1);
          mplier_d = mplier_sh;
          if (cnt_q == CNT_LAST || early) begin
            result_d = sel;
            rd_out_d = rd_q;
            state_d  = S_DONE;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
  assign bus.wb_en  = (state_q == S_DONE) && (rd_out_q != '0);
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative; latency expectations follow MDU_EARLY_OUT_EN.
module tb_mdu_iterative;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iterative_if #(.XLEN(32)) bus ();
  mdu_iterative #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Multiply latency: 33 normally; with early-out, E0 plus one cycle per multiplier bit (at least one).
  function automatic int unsigned mul_lat(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] m;
    int unsigned n;
    m = (f3 == 3'd1 && b[31]) ? -b : b;
    n = 1;
    for (int i = 1; i < 32; i++) if (m[i]) n = i + 1;
    return EARLY ? n + 1 : 33;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int unsigned exp_lat);
    int unsigned lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      if (lat == 1) check({tag, " busy"}, 32'(bus.busy), 32'd1);
      if (bus.done) seen = 1'b1;
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    check({tag, " wb_en"}, 32'(bus.wb_en), 32'(rd != 5'd0));
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, " hold"}, bus.result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int unsigned dones;
    logic [31:0] cap_res;
    logic [4:0] cap_rd;

    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
    #12;
    check("reset outs", {27'd0, bus.busy, bus.done, bus.wb_en, 2'd0}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, mul_lat(3'd0, 32'd6));
    run_op("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h0, mul_lat(3'd1, 32'hFFFFFFFF));
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF, mul_lat(3'd2, 32'hFFFFFFFF));
    run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, mul_lat(3'd3, 32'hFFFFFFFF));
    run_op("mul neg", 3'd0, 32'hFFFFFFFD, 32'd5, 5'd4, 32'hFFFFFFF1, mul_lat(3'd0, 32'd5));
    run_op("mul x1", 3'd0, 32'd5, 32'd1, 5'd6, 32'd5, mul_lat(3'd0, 32'd1));
    run_op("mul x0", 3'd0, 32'd1234, 32'd0, 5'd6, 32'd0, mul_lat(3'd0, 32'd0));
    run_op("mulhu x1", 3'd3, 32'hDEADBEEF, 32'd1, 5'd6, 32'd0, mul_lat(3'd3, 32'd1));
    run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, 33);
    run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, 33);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 33);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run_op("divu big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 33);
    run_op("divu by0", 3'd5, 32'd9, 32'd0, 5'd13, 32'hFFFFFFFF, 1);
    run_op("rem by0", 3'd6, 32'd9, 32'd0, 5'd14, 32'd9, 1);
    run_op("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 1);
    run_op("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    run_op("rd0", 3'd5, 32'd20, 32'd4, 5'd0, 32'd5, 33);

    // start re-asserted during CALC must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7; bus.rd_in = 5'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_val = 32'd2; bus.rs2_val = 32'd3; bus.rd_in = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0; cap_res = '0; cap_rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        cap_res = bus.result;
        cap_rd = bus.rd_out;
      end
    end
    check("ignore start dones", dones, 32'd1);
    check("ignore start result", cap_res, 32'd14);
    check("ignore start rd", 32'(cap_rd), 32'd3);
    last_res = 32'd14;

    // flush at CALC cycle 20
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_val = 32'd50; bus.rs2_val = 32'd5; bus.rd_in = 5'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 19; i++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", {30'd0, bus.busy, bus.done}, 32'd0);
    check("flush result", bus.result, last_res);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush no done", dones, 32'd0);

    // flush wins over start in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5; bus.rs1_val = 32'd8; bus.rs2_val = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start busy", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3; bus.rd_in = 5'd17;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst outs", {27'd0, bus.busy, bus.done, bus.wb_en, 2'd0}, 32'd0);
    check("async rst result", bus.result, 32'd0);
    check("async rst rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after rst", 3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
